instruction_memory_arbiter: RTL
===============================

// Module: instruction_memory_arbiter
// PURPOSE
//  Shares one synchronous-read instruction memory among N_REQ basic_block engines.
//  Each requester port mirrors the basic_block memory handshake (valid+addr out, one-cycle ready pulse in, data next cycle).
//  Round-robin, one outstanding read at a time.
//  Sits between the basic_block array and the instruction BRAM inside the regex core.
// PARAMETERS
//  N_REQ             4   number of basic_block requesters (>=2)
//  MEMORY_WIDTH      16  instruction word width
//  MEMORY_ADDR_WIDTH 11  instruction address width
// PORTS
//  clk        in   1                      clock; all state on rising edge
//  reset      in   1                      asynchronous, active-low (0 = reset asserted)
//  req_valid  in   N_REQ                  per-requester fetch request (basic_block memory_valid)
//  req_addr   in   N_REQ*MEMORY_ADDR_WIDTH per-requester address; slice i = [i*AW +: AW]
//  req_ready  out  N_REQ                  one-hot grant pulse (basic_block memory_ready)
//  req_data   out  MEMORY_WIDTH           shared read data, broadcast to all requesters
//  mem_en     out  1                      memory read enable
//  mem_addr   out  MEMORY_ADDR_WIDTH      memory read address
//  mem_data   in   MEMORY_WIDTH           memory read data, valid one cycle after mem_en
//  busy       out  1                      high in GRANT or RESP
// BEHAVIOUR
//  - Reset (reset==0, async): state=IDLE; rr_ptr=0; grant_idx=0; req_ready=0; mem_en=0; mem_addr=0; busy=0; req_data=0.
//  - FSM states: IDLE, GRANT, RESP. All outputs are registered except req_data.
//  - IDLE, any req_valid:
//    - Pick the first set bit scanning from rr_ptr upward, modulo N_REQ.
//    - Latch grant_idx and that requester's address; next state GRANT.
//  - IDLE, no req_valid: remain in IDLE.
//  - GRANT (one cycle):
//    - req_ready[grant_idx]=1, others 0.
//    - mem_en=1; mem_addr = latched address.
//    - rr_ptr <= (grant_idx+1) mod N_REQ.
//    - Next state RESP.
//  - RESP (one cycle):
//    - req_data = mem_data, combinational passthrough. Each requester samples it the cycle after its own req_ready.
//    - Arbitration runs again as in IDLE, using the updated rr_ptr.
//    - If any req_valid is set, go to GRANT (back-to-back). Otherwise go to IDLE.
//  - Outside RESP: req_data holds the last returned word from a registered copy.
//  - Timing: one grant per 2 cycles at peak. Latency from req_valid sampled in IDLE to req_ready is 1 cycle; to data is 2 cycles.
//  - Requesters hold req_valid and req_addr until req_ready. The address is captured at arbitration.
//  - If a requester drops req_valid after selection, the grant is still issued and the read still performed.
//  - A requester whose req_valid stays high after its grant is re-arbitrated normally. It gets no priority.
//  - Fairness: with all N_REQ requesting continuously, each is granted exactly once every N_REQ grants.
//  - Simultaneous requests: the rr_ptr position wins; ties are impossible (scan order is fixed).
//  - rr_ptr wraps from N_REQ-1 to 0.
//  - Reset mid-operation:
//    - An in-flight grant or read is abandoned; no req_ready or req_data is produced for it after reset release.
//    - The first arbitration after release starts from rr_ptr=0.
//  - req_ready and mem_en are never high for two consecutive cycles.
//  - Never more than one req_ready bit is high.
// TESTING
//  1 Reset: drive reset=0 mid-GRANT -> req_ready=0, mem_en=0, busy=0 immediately. After release, IDLE with rr_ptr=0.
//  2 Single fetch:
//    - Stimulus: req_valid=4'b0100, addr[2]=11'h0AB; memory holds {SPLIT,8'h11} at 0x0AB.
//    - Response: next cycle req_ready=4'b0100, mem_addr=0x0AB; following cycle req_data={SPLIT,8'h11}.
//  3 Contention: req_valid=4'b1111 held -> grants in order 0,1,2,3,0. Each is 2 cycles apart; each req_data matches its address.
//  4 Wrap/priority: after a grant to requester 3, raise req_valid=4'b1001 -> requester 0 granted first, then 3.
//  5 Integration:
//    - Two basic_block instances share one memory; both load pc 8'hAB over SPLIT 8'h11.
//    - Each outputs pcs 0xAC and 0xBC, and no fetch handshake checks fail.
//  6 Assertions:
//    - req_ready is one-hot or zero.
//    - mem_en is never high on consecutive cycles.
//    - mem_en == |req_ready, and mem_addr matches the granted requester's address.

Source files
------------

// File: rtl/instruction_memory_arbiter.sv
// ----------------------------------------------------------------------------
// instruction_memory_arbiter
//
// Shares one synchronous-read instruction memory among N_REQ basic_block
// engines. Requests are served round-robin with one outstanding read at a time.
// Each grant takes two cycles: GRANT drives the one-hot ready pulse and the
// memory read. RESP passes the returned word straight through to the shared
// data bus and re-arbitrates, so back-to-back grants are possible.
//
// Ports
//   clk        in   clock, all state on the rising edge
//   reset      in   asynchronous reset, active low
//   req_valid  in   [N_REQ]     per-requester fetch request
//   req_addr   in   [N_REQ*AW]  per-requester address, slice i = [i*AW +: AW]
//   req_ready  out  [N_REQ]     one-hot grant pulse (high for the GRANT cycle)
//   req_data   out  [DW]        shared read data, broadcast to all requesters
//   mem_en     out  memory read enable
//   mem_addr   out  [AW]        memory read address
//   mem_data   in   [DW]        memory read data, valid one cycle after mem_en
//   busy       out  high while in GRANT or RESP
// ----------------------------------------------------------------------------
module instruction_memory_arbiter #(
    parameter int N_REQ             = 4,
    parameter int MEMORY_WIDTH      = 16,
    parameter int MEMORY_ADDR_WIDTH = 11
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [N_REQ-1:0]                   req_valid,
    input  logic [N_REQ*MEMORY_ADDR_WIDTH-1:0] req_addr,
    output logic [N_REQ-1:0]                   req_ready,
    output logic [MEMORY_WIDTH-1:0]            req_data,
    output logic                               mem_en,
    output logic [MEMORY_ADDR_WIDTH-1:0]       mem_addr,
    input  logic [MEMORY_WIDTH-1:0]            mem_data,
    output logic                               busy
);

    localparam int IW = $clog2(N_REQ);
    localparam int AW = MEMORY_ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t                  state_q;
    logic [IW-1:0]           rr_ptr_q;
    logic [IW-1:0]           grant_idx_q;
    logic [N_REQ-1:0]        req_ready_q;
    logic                    mem_en_q;
    logic [AW-1:0]           mem_addr_q;
    logic                    busy_q;
    logic [MEMORY_WIDTH-1:0] data_q;

    // Arbitration result for the current cycle.
    logic                    pick_found;
    logic [IW-1:0]           pick_idx;
    logic [AW-1:0]           pick_addr;
    logic [IW-1:0]           grant_next;

    // Scan from rr_ptr upward, modulo N_REQ. The first set bit wins, so two
    // requesters can never tie.
    always_comb begin
        // NOTE: every signal written here gets a default before any branch;
        // a path that leaves one unassigned would infer a latch.
        int cand;
        pick_found = 1'b0;
        pick_idx   = rr_ptr_q;
        cand       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = (int'(rr_ptr_q) + k) % N_REQ;
            if (!pick_found && req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = IW'(cand);
            end
        end
    end

    assign pick_addr  = req_addr[pick_idx*AW +: AW];
    assign grant_next = (grant_idx_q == IW'(N_REQ - 1)) ? '0 : grant_idx_q + 1'b1;

    // All outputs except req_data are registered. The ready pulse and mem_en
    // are set on the edge that enters GRANT and cleared by default on the
    // next edge. GRANT is always followed by RESP, so neither signal can be
    // high for two cycles in a row.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_idx_q <= '0;
            req_ready_q <= '0;
            mem_en_q    <= 1'b0;
            mem_addr_q  <= '0;
            busy_q      <= 1'b0;
            data_q      <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            req_ready_q <= '0;
            mem_en_q    <= 1'b0;
            case (state_q)
                IDLE, RESP: begin
                    // Keep the returned word so req_data holds it outside RESP.
                    if (state_q == RESP) begin
                        data_q <= mem_data;
                    end
                    if (pick_found) begin
                        state_q     <= GRANT;
                        grant_idx_q <= pick_idx;
                        // The address is captured here. The requester may
                        // change it once its ready pulse has been seen.
                        mem_addr_q  <= pick_addr;
                        req_ready_q <= {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
                        mem_en_q    <= 1'b1;
                        busy_q      <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                GRANT: begin
                    rr_ptr_q <= grant_next;
                    state_q  <= RESP;
                    busy_q   <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign mem_en    = mem_en_q;
    assign mem_addr  = mem_addr_q;
    assign busy      = busy_q;
    // The memory word arrives during RESP and passes straight through, so the
    // requester sees it the cycle after its ready pulse.
    assign req_data  = (state_q == RESP) ? mem_data : data_q;

endmodule
